// File: rtl/pim_dma_engine_if.sv
// ============================================================================
//  Module      : pim_dma_engine_if
//  Description : Bundles the DMA command port, the shared data-memory bus and
//                the PIM buffer port of pim_dma_engine.
//                slave  - engine side (drives *_o members)
//                master - core / memory / PIM side (drives *_i members)
//  Ports       : command  : dma_en_i, dma_funct3_i, dma_sel_pim_i,
//                           dma_size_i, dma_mem_addr_i, dma_busy_o, dma_err_o
//                memory   : req_dmem_o, gnt_dmem_i, mem_addr_o, mem_rd_data_i,
//                           mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o
//                PIM      : pim_sel_o, pim_addr_o, pim_wr_data_o, pim_we_o,
//                           pim_re_o, pim_rd_data_i
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pim_dma_engine_if #(
  parameter int XLEN    = 32,
  parameter int SIZE_W  = 13,
  parameter int PIM_AW  = 11,
  parameter int NUM_PIM = 4
);
  // command
  logic                dma_en_i;
  logic [2:0]          dma_funct3_i;
  logic [NUM_PIM-1:0]  dma_sel_pim_i;
  logic [SIZE_W-1:0]   dma_size_i;
  logic [XLEN-1:0]     dma_mem_addr_i;
  logic                dma_busy_o;
  logic                dma_err_o;
  // data memory
  logic                req_dmem_o;
  logic                gnt_dmem_i;
  logic [XLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_rd_data_i;
  logic [XLEN-1:0]     mem_wr_data_o;
  logic [3:0]          mem_size_o;
  logic                mem_read_o;
  logic                mem_write_o;
  // PIM buffers
  logic [NUM_PIM-1:0]  pim_sel_o;
  logic [PIM_AW-1:0]   pim_addr_o;
  logic [XLEN-1:0]     pim_wr_data_o;
  logic                pim_we_o;
  logic                pim_re_o;
  logic [XLEN-1:0]     pim_rd_data_i;

  modport slave (
    input  dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    output dma_busy_o, dma_err_o,
    output req_dmem_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    input  gnt_dmem_i, mem_rd_data_i,
    output pim_sel_o, pim_addr_o, pim_wr_data_o, pim_we_o, pim_re_o,
    input  pim_rd_data_i
  );

  modport master (
    output dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    input  dma_busy_o, dma_err_o,
    input  req_dmem_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    output gnt_dmem_i, mem_rd_data_i,
    input  pim_sel_o, pim_addr_o, pim_wr_data_o, pim_we_o, pim_re_o,
    output pim_rd_data_i
  );
endinterface

`default_nettype wire

// File: rtl/pim_dma_engine.sv
// ============================================================================
//  Module      : pim_dma_engine
//  Description : DMA responder moving whole 32-bit words between data memory
//                and one of NUM_PIM PIM buffers. One command per dma_en_i
//                pulse; dma_busy_o stays high for the whole transfer.
//                funct3 000 = MEM->PIM, 001 = PIM->MEM, others rejected.
//  Ports       : clk_i       - clock
//                rst_ni      - asynchronous active-low reset
//                dma_bus     - pim_dma_engine_if.slave (command, memory, PIM)
//                done_irq_o  - one-cycle completion pulse (PIM_DMA_DONE_IRQ_EN)
//  Options     : define PIM_DMA_DONE_IRQ_EN to add done_irq_o
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pim_dma_engine #(
  parameter int XLEN    = 32,
  parameter int SIZE_W  = 13,
  parameter int PIM_AW  = 11,
  parameter int NUM_PIM = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pim_dma_engine_if.slave dma_bus
`ifdef PIM_DMA_DONE_IRQ_EN
  ,
  output logic            done_irq_o
`endif
);

  localparam int WCNT_W = SIZE_W - 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M_RD = 3'd1,
    S_P_WR = 3'd2,
    S_P_RD = 3'd3,
    S_M_WR = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [NUM_PIM-1:0]  r_sel;
  logic [XLEN-1:0]     r_addr;
  logic [WCNT_W-1:0]   r_rem;     // words still to move
  logic [PIM_AW-1:0]   r_idx;     // PIM word address, wraps naturally
  logic [XLEN-1:0]     r_wdata;
  logic                r_wfirst;  // first cycle of M_WR: PIM data is on the bus now
  logic                r_err;

  logic [WCNT_W-1:0]   w_wcnt;
  logic                w_onehot;
  logic                w_cmd_valid;
  logic                w_last;
  logic                w_accept;
  logic                w_reject;

  logic                w_req;
  logic                w_mem_rd;
  logic                w_mem_wr;
  logic [XLEN-1:0]     w_mem_addr;
  logic [XLEN-1:0]     w_mem_wdata;
  logic [3:0]          w_mem_size;
  logic                w_pim_we;
  logic                w_pim_re;
  logic [PIM_AW-1:0]   w_pim_addr;
  logic [XLEN-1:0]     w_pim_wdata;

  // Byte-granular length bits are dropped: transfers are whole words.
  logic                w_unused;
  assign w_unused = ^dma_bus.dma_size_i[1:0];

  assign w_wcnt      = dma_bus.dma_size_i[SIZE_W-1:2];
  assign w_onehot    = (dma_bus.dma_sel_pim_i != '0) &&
                       ((dma_bus.dma_sel_pim_i & (dma_bus.dma_sel_pim_i - NUM_PIM'(1))) == '0);
  assign w_cmd_valid = w_onehot && (dma_bus.dma_funct3_i[2:1] == 2'b00);
  assign w_last      = (r_rem == WCNT_W'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus outputs. Everything is decoded from r_state so an
  // asynchronous reset forces every output low immediately. Byte strobes are
  // only driven while a memory access is presented.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_req       = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_size  = 4'b0000;
    w_pim_we    = 1'b0;
    w_pim_re    = 1'b0;
    w_pim_addr  = '0;
    w_pim_wdata = '0;

    case (r_state)
      S_IDLE: begin
        if (dma_bus.dma_en_i) begin
          if (w_cmd_valid) begin
            w_accept = 1'b1;
            if (w_wcnt == '0)
              w_next = S_DONE;
            else if (dma_bus.dma_funct3_i[0])
              w_next = S_P_RD;
            else
              w_next = S_M_RD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_M_RD: begin
        w_req      = 1'b1;
        w_mem_rd   = 1'b1;
        w_mem_addr = r_addr;
        w_mem_size = 4'b1111;
        if (dma_bus.gnt_dmem_i)
          w_next = S_P_WR;
      end
      S_P_WR: begin
        // Read data returns the cycle after the grant, so forward it straight in.
        w_pim_we    = 1'b1;
        w_pim_addr  = r_idx;
        w_pim_wdata = dma_bus.mem_rd_data_i;
        w_next      = w_last ? S_DONE : S_M_RD;
      end
      S_P_RD: begin
        w_pim_re   = 1'b1;
        w_pim_addr = r_idx;
        w_next     = S_M_WR;
      end
      S_M_WR: begin
        w_req       = 1'b1;
        w_mem_wr    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_size  = 4'b1111;
        w_mem_wdata = r_wfirst ? dma_bus.pim_rd_data_i : r_wdata;
        if (dma_bus.gnt_dmem_i)
          w_next = w_last ? S_DONE : S_P_RD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel    <= '0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_wfirst <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel  <= dma_bus.dma_sel_pim_i;
        r_addr <= dma_bus.dma_mem_addr_i;
        r_rem  <= w_wcnt;
        r_idx  <= '0;
        r_err  <= 1'b0;
      end
      if (w_reject)
        r_err <= 1'b1;

      case (r_state)
        S_P_WR: begin
          r_idx  <= r_idx + PIM_AW'(1);
          r_addr <= r_addr + XLEN'(4);
          r_rem  <= r_rem - WCNT_W'(1);
        end
        S_P_RD: begin
          r_wfirst <= 1'b1;
        end
        S_M_WR: begin
          // Hold the PIM word so the write data stays stable across a stall.
          if (r_wfirst) begin
            r_wdata  <= dma_bus.pim_rd_data_i;
            r_wfirst <= 1'b0;
          end
          if (dma_bus.gnt_dmem_i) begin
            r_idx  <= r_idx + PIM_AW'(1);
            r_addr <= r_addr + XLEN'(4);
            r_rem  <= r_rem - WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIM_DMA_DONE_IRQ_EN
  // Registered so the pulse lands on the first idle cycle, when busy drops.
  logic r_irq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_irq <= 1'b0;
    else
      r_irq <= (r_state == S_DONE);
  end
  assign done_irq_o = r_irq;
`endif

  assign dma_bus.dma_busy_o    = (r_state != S_IDLE);
  assign dma_bus.dma_err_o     = r_err;
  assign dma_bus.req_dmem_o    = w_req;
  assign dma_bus.mem_read_o    = w_mem_rd;
  assign dma_bus.mem_write_o   = w_mem_wr;
  assign dma_bus.mem_addr_o    = w_mem_addr;
  assign dma_bus.mem_wr_data_o = w_mem_wdata;
  assign dma_bus.mem_size_o    = w_mem_size;
  assign dma_bus.pim_sel_o     = (r_state != S_IDLE) ? r_sel : '0;
  assign dma_bus.pim_addr_o    = w_pim_addr;
  assign dma_bus.pim_wr_data_o = w_pim_wdata;
  assign dma_bus.pim_we_o      = w_pim_we;
  assign dma_bus.pim_re_o      = w_pim_re;

endmodule

`default_nettype wire

// File: tb/tb_pim_dma_engine.sv
// ============================================================================
//  Module      : tb_pim_dma_engine
//  Description : Directed self-checking bench for pim_dma_engine with small
//                data-memory and PIM buffer models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pim_dma_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pim_dma_engine_if #(.XLEN(32), .SIZE_W(13), .PIM_AW(11), .NUM_PIM(4)) bus ();

`ifdef PIM_DMA_DONE_IRQ_EN
  logic irq;
`endif

  pim_dma_engine #(.XLEN(32), .SIZE_W(13), .PIM_AW(11), .NUM_PIM(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .dma_bus (bus)
`ifdef PIM_DMA_DONE_IRQ_EN
    ,
    .done_irq_o (irq)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- models and monitors ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] pim [0:2047];

  logic [10:0] pw_addr [0:63];
  logic [31:0] pw_data [0:63];
  logic [3:0]  pw_sel  [0:63];
  logic [31:0] mw_addr [0:63];
  logic [31:0] mw_data [0:63];
  logic [3:0]  mw_size [0:63];
  int pw_n = 0, mw_n = 0, busy_total = 0, act_total = 0, irq_total = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rd_data_i <= '0;
      bus.pim_rd_data_i <= '0;
    end else begin
      if (bus.req_dmem_o && bus.gnt_dmem_i && bus.mem_read_o)
        bus.mem_rd_data_i <= mem[bus.mem_addr_o[13:2]];
      if (bus.pim_re_o)
        bus.pim_rd_data_i <= pim[bus.pim_addr_o];
    end
  end

  always @(posedge clk) begin
    if (bus.dma_busy_o) busy_total++;
    if (bus.req_dmem_o || bus.pim_we_o || bus.pim_re_o) act_total++;
`ifdef PIM_DMA_DONE_IRQ_EN
    if (irq) irq_total++;
`endif
    if (bus.pim_we_o && pw_n < 64) begin
      pw_addr[pw_n] = bus.pim_addr_o;
      pw_data[pw_n] = bus.pim_wr_data_o;
      pw_sel[pw_n]  = bus.pim_sel_o;
      pw_n++;
    end
    if (bus.req_dmem_o && bus.gnt_dmem_i && bus.mem_write_o && mw_n < 64) begin
      mw_addr[mw_n] = bus.mem_addr_o;
      mw_data[mw_n] = bus.mem_wr_data_o;
      mw_size[mw_n] = bus.mem_size_o;
      mw_n++;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic cmd(input logic [2:0] f3, input logic [3:0] sel,
                     input logic [12:0] size, input logic [31:0] addr);
    @(negedge clk);
    bus.dma_funct3_i   = f3;
    bus.dma_sel_pim_i  = sel;
    bus.dma_size_i     = size;
    bus.dma_mem_addr_i = addr;
    bus.dma_en_i       = 1'b1;
    @(negedge clk);
    bus.dma_en_i       = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.dma_busy_o === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.dma_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout busy=%b required 0", name, bus.dma_busy_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.dma_busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b required 0", bus.dma_busy_o); end
    vectors++;
    if (bus.dma_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b required 0", bus.dma_err_o); end
    vectors++;
    if ({bus.req_dmem_o, bus.mem_read_o, bus.mem_write_o, bus.pim_we_o, bus.pim_re_o} !== 5'b0) begin
      miscompares++; $display("FAIL reset_strobes got %b required 00000",
        {bus.req_dmem_o, bus.mem_read_o, bus.mem_write_o, bus.pim_we_o, bus.pim_re_o});
    end
    vectors++;
    if (bus.pim_sel_o !== 4'b0) begin miscompares++; $display("FAIL reset_sel got %b required 0000", bus.pim_sel_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_to_pim();
    int pw0, b0;
    pw0 = pw_n; b0 = busy_total;
    bus.gnt_dmem_i = 1'b1;
    cmd(3'b000, 4'b0001, 13'd16, 32'h0000_2000);
    vectors++;
    if (bus.dma_busy_o !== 1'b1) begin miscompares++; $display("FAIL m2p_busy_start got %b required 1", bus.dma_busy_o); end
    wait_idle("m2p");
    vectors++;
    if (busy_total - b0 !== 9) begin miscompares++; $display("FAIL m2p_busy_cycles got %0d required 9", busy_total - b0); end
    vectors++;
    if (pw_n - pw0 !== 4) begin miscompares++; $display("FAIL m2p_write_count got %0d required 4", pw_n - pw0); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pw_addr[pw0+i] !== 11'(i) || pw_data[pw0+i] !== (32'hA0A0_0000 + 32'(i)) || pw_sel[pw0+i] !== 4'b0001) begin
        miscompares++;
        $display("FAIL m2p_word%0d got addr=%0d data=%h sel=%b required addr=%0d data=%h sel=0001",
          i, pw_addr[pw0+i], pw_data[pw0+i], pw_sel[pw0+i], i, 32'hA0A0_0000 + 32'(i));
      end
    end
    vectors++;
    if (bus.pim_sel_o !== 4'b0) begin miscompares++; $display("FAIL m2p_sel_idle got %b required 0000", bus.pim_sel_o); end
  endtask

  task automatic test_pim_to_mem();
    int mw0, b0;
    mw0 = mw_n; b0 = busy_total;
    bus.gnt_dmem_i = 1'b1;
    cmd(3'b001, 4'b0100, 13'd8, 32'h0000_3000);
    wait_idle("p2m");
    vectors++;
    if (busy_total - b0 !== 5) begin miscompares++; $display("FAIL p2m_busy_cycles got %0d required 5", busy_total - b0); end
    vectors++;
    if (mw_n - mw0 !== 2) begin miscompares++; $display("FAIL p2m_write_count got %0d required 2", mw_n - mw0); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (mw_addr[mw0+i] !== (32'h3000 + 32'(4*i)) || mw_data[mw0+i] !== (32'hB0B0_0000 + 32'(i)) || mw_size[mw0+i] !== 4'b1111) begin
        miscompares++;
        $display("FAIL p2m_word%0d got addr=%h data=%h size=%b required addr=%h data=%h size=1111",
          i, mw_addr[mw0+i], mw_data[mw0+i], mw_size[mw0+i], 32'h3000 + 32'(4*i), 32'hB0B0_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_grant_stall();
    int pw0, b0;
    pw0 = pw_n; b0 = busy_total;
    bus.gnt_dmem_i = 1'b0;
    cmd(3'b000, 4'b0010, 13'd4, 32'h0000_2100);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.req_dmem_o !== 1'b1 || bus.mem_read_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h2100) begin
        miscompares++;
        $display("FAIL stall_hold%0d got req=%b rd=%b wr=%b addr=%h required req=1 rd=1 wr=0 addr=00002100",
          i, bus.req_dmem_o, bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o);
      end
      @(negedge clk);
    end
    bus.gnt_dmem_i = 1'b1;
    wait_idle("stall");
    vectors++;
    if (busy_total - b0 !== 6) begin miscompares++; $display("FAIL stall_busy_cycles got %0d required 6", busy_total - b0); end
    vectors++;
    if (pw_n - pw0 !== 1 || pw_data[pw0] !== 32'hC0C0_C0C0 || pw_addr[pw0] !== 11'd0) begin
      miscompares++;
      $display("FAIL stall_pim_write got count=%0d data=%h addr=%0d required count=1 data=c0c0c0c0 addr=0",
        pw_n - pw0, pw_data[pw0], pw_addr[pw0]);
    end
  endtask

  task automatic test_reject_zero();
    int b0, a0;
    b0 = busy_total; a0 = act_total;
    cmd(3'b010, 4'b0001, 13'd16, 32'h0000_2000);
    vectors++;
    if (bus.dma_err_o !== 1'b1 || bus.dma_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reject_funct3 got err=%b busy=%b required err=1 busy=0", bus.dma_err_o, bus.dma_busy_o);
    end
    cmd(3'b000, 4'b0011, 13'd16, 32'h0000_2000);
    vectors++;
    if (bus.dma_err_o !== 1'b1 || bus.dma_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reject_sel got err=%b busy=%b required err=1 busy=0", bus.dma_err_o, bus.dma_busy_o);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_total - b0 !== 0) begin miscompares++; $display("FAIL reject_busy_cycles got %0d required 0", busy_total - b0); end
    cmd(3'b000, 4'b0001, 13'd3, 32'h0000_2000);
    vectors++;
    if (bus.dma_err_o !== 1'b0 || bus.dma_busy_o !== 1'b1) begin
      miscompares++; $display("FAIL zero_len_start got err=%b busy=%b required err=0 busy=1", bus.dma_err_o, bus.dma_busy_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.dma_busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_len_end got busy=%b required 0", bus.dma_busy_o); end
    vectors++;
    if (busy_total - b0 !== 1 || act_total - a0 !== 0) begin
      miscompares++; $display("FAIL zero_len_activity got busy=%0d bus=%0d required busy=1 bus=0", busy_total - b0, act_total - a0);
    end
  endtask

  task automatic test_reset_mid();
    int pw0, b0, n;
    pw0 = pw_n;
    bus.gnt_dmem_i = 1'b1;
    cmd(3'b000, 4'b1000, 13'd32, 32'h0000_2000);
    n = 0;
    while (pw_n - pw0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (pw_n - pw0 < 2) begin miscompares++; $display("FAIL rstmid_progress got %0d required 2", pw_n - pw0); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.dma_busy_o !== 1'b0 || bus.pim_sel_o !== 4'b0 || bus.mem_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_async got busy=%b sel=%b addr=%h required 0 0000 0",
        bus.dma_busy_o, bus.pim_sel_o, bus.mem_addr_o);
    end
    vectors++;
    if ({bus.req_dmem_o, bus.mem_read_o, bus.mem_write_o, bus.pim_we_o, bus.pim_re_o} !== 5'b0) begin
      miscompares++; $display("FAIL rstmid_strobes got %b required 00000",
        {bus.req_dmem_o, bus.mem_read_o, bus.mem_write_o, bus.pim_we_o, bus.pim_re_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pw0 = pw_n; b0 = busy_total;
    cmd(3'b000, 4'b0001, 13'd16, 32'h0000_2000);
    wait_idle("rstmid_restart");
    vectors++;
    if (busy_total - b0 !== 9 || pw_n - pw0 !== 4) begin
      miscompares++; $display("FAIL rstmid_restart got busy=%0d writes=%0d required 9 4", busy_total - b0, pw_n - pw0);
    end
    vectors++;
    if (pw_addr[pw0] !== 11'd0 || pw_data[pw0] !== 32'hA0A0_0000) begin
      miscompares++; $display("FAIL rstmid_first_word got addr=%0d data=%h required 0 a0a00000", pw_addr[pw0], pw_data[pw0]);
    end
  endtask

`ifdef PIM_DMA_DONE_IRQ_EN
  task automatic test_done_irq();
    int i0;
    i0 = irq_total;
    bus.gnt_dmem_i = 1'b1;
    cmd(3'b001, 4'b0001, 13'd8, 32'h0000_3000);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got %b required 0", irq); end
    wait_idle("irq");
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_at_fall got %b required 1", irq); end
    repeat (3) @(negedge clk);
    vectors++;
    if (irq_total - i0 !== 1) begin miscompares++; $display("FAIL irq_count got %0d required 1", irq_total - i0); end
    i0 = irq_total;
    cmd(3'b111, 4'b0001, 13'd8, 32'h0000_3000);
    repeat (3) @(negedge clk);
    vectors++;
    if (irq_total - i0 !== 0) begin miscompares++; $display("FAIL irq_reject got %0d required 0", irq_total - i0); end
  endtask
`endif

  initial begin
    bus.dma_en_i       = 1'b0;
    bus.dma_funct3_i   = 3'b000;
    bus.dma_sel_pim_i  = 4'b0000;
    bus.dma_size_i     = '0;
    bus.dma_mem_addr_i = '0;
    bus.gnt_dmem_i     = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    for (int i = 0; i < 8; i++)    mem[12'h800 + i] = 32'hA0A0_0000 + 32'(i);
    mem[12'h840] = 32'hC0C0_C0C0;
    for (int i = 0; i < 2048; i++) pim[i] = 32'hB0B0_0000 + 32'(i);

    test_reset();
    test_mem_to_pim();
    test_pim_to_mem();
    test_grant_stall();
    test_reject_zero();
    test_reset_mid();
`ifdef PIM_DMA_DONE_IRQ_EN
    test_done_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
